des_core: RTL and testbench

DES_CORE -- requirements
Module: des_core

---
 rtl/des_core.sv | 176 +++++++++++++++++
 tb/tb_des_core.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_core.sv
// Iterative single-DES encryption core: one Feistel round per clock through a
// shared round function, with an IDLE/ROUND/DONE sequencer.
module des_core (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_cleartext,
  input  logic [63:0] i_key,
  input  logic        i_dv,
  output logic [63:0] o_ciphertext,
  output logic        o_dv
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  // Tables use 1-based bit numbers where bit 1 is the MSB of the source word.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box is 64 nibbles in row-major order, entry 0 in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - IP_T[k])];
    return y;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[6'(63 - k)] = x[6'(64 - FP_T[k])];
    return y;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int k = 0; k < 56; k++) y[6'(55 - k)] = x[6'(64 - PC1_T[k])];
    return y;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[6'(56 - PC2_T[k])];
    return y;
  endfunction

  function automatic logic [47:0] f_e(input logic [31:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[6'(47 - k)] = x[5'(32 - E_T[k])];
    return y;
  endfunction

  function automatic logic [31:0] f_p(input logic [31:0] x);
    logic [31:0] y;
    for (int k = 0; k < 32; k++) y[5'(31 - k)] = x[5'(32 - P_T[k])];
    return y;
  endfunction

  // Outer bits of each 6-bit group select the row, inner four the column.
  function automatic logic [31:0] f_sbox(input logic [47:0] x);
    logic [5:0]  six;
    logic [5:0]  idx;
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      six = x[6'(47 - 6 * i) -: 6];
      idx = {six[5], six[0], six[4:1]};
      y[5'(31 - 4 * i) -: 4] = SBOX[i][8'(255 - 4 * int'(idx)) -: 4];
    end
    return y;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [3:0]  cnt;

  logic        one_shift;
  logic [27:0] c_rot, d_rot;
  logic [47:0] subkey;
  logic [31:0] l_nxt, r_nxt;

  // Round datapath: rotate key halves, derive subkey, apply f and swap.
  always_comb begin
    one_shift = (cnt == 4'd0) || (cnt == 4'd1) || (cnt == 4'd8) || (cnt == 4'd15);
    c_rot     = one_shift ? {c_q[26:0], c_q[27]} : {c_q[25:0], c_q[27:26]};
    d_rot     = one_shift ? {d_q[26:0], d_q[27]} : {d_q[25:0], d_q[27:26]};
    subkey    = f_pc2({c_rot, d_rot});
    l_nxt     = r_q;
    r_nxt     = l_q ^ f_p(f_sbox(f_e(r_q) ^ subkey));
  end

  always_comb begin
    state_nxt = state;
    o_dv      = 1'b0;
    case (state)
      IDLE:    if (i_dv) state_nxt = ROUND;
      ROUND:   if (cnt == 4'd15) state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        o_dv      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      l_q          <= '0;
      r_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      cnt          <= '0;
      o_ciphertext <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_dv) begin
            {l_q, r_q} <= f_ip(i_cleartext);
            {c_q, d_q} <= f_pc1(i_key);
            cnt        <= '0;
          end
        end
        ROUND: begin
          l_q <= l_nxt;
          r_q <= r_nxt;
          c_q <= c_rot;
          d_q <= d_rot;
          cnt <= cnt + 4'd1;
          // Final round output goes through the swap and FP straight to the result.
          if (cnt == 4'd15) o_ciphertext <= f_fp({r_nxt, l_nxt});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_core.sv
// Randomized scoreboard bench for des_core with a transaction-level DES model.
module tb_des_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] cleartext = '0;
  logic [63:0] key = '0;
  logic        dv = 1'b0;
  logic [63:0] ciphertext;
  logic        ct_dv;

  des_core dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cleartext (cleartext),
    .i_key       (key),
    .i_dv        (dv),
    .o_ciphertext(ciphertext),
    .o_dv        (ct_dv)
  );

  always #5 clk = ~clk;

  typedef int tab_t [64];

  localparam tab_t IP_T = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam tab_t FP_T = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam tab_t PC1_T = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4,
    0, 0, 0, 0, 0, 0, 0, 0};
  localparam tab_t PC2_T = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam tab_t E_T = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam tab_t P_T = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam int SB [8][4][16] = '{
    '{'{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7},
      '{0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8},
      '{4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0},
      '{15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13}},
    '{'{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10},
      '{3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5},
      '{0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15},
      '{13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9}},
    '{'{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8},
      '{13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1},
      '{13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7},
      '{1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12}},
    '{'{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15},
      '{13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9},
      '{10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4},
      '{3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14}},
    '{'{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9},
      '{14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6},
      '{4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14},
      '{11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3}},
    '{'{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11},
      '{10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8},
      '{9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6},
      '{4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13}},
    '{'{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1},
      '{13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6},
      '{1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2},
      '{6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12}},
    '{'{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7},
      '{1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2},
      '{7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8},
      '{2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}}};

  // Generic FIPS-numbered permutation on right-aligned words.
  function automatic logic [63:0] perm(input logic [63:0] x, input int in_w,
                                       input int out_w, input tab_t t);
    logic [63:0] y;
    y = '0;
    for (int k = 0; k < out_w; k++) y[6'(out_w - 1 - k)] = x[6'(in_w - t[k])];
    return y;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [55:0] w;
    w = {x, x} << (n % 28);
    return w[55:28];
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] t;
    logic [47:0] x;
    logic [5:0]  six;
    logic [31:0] s;
    int          row, col;
    t = perm({32'h0, r}, 32, 48, E_T);
    x = t[47:0] ^ k;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      six = x[6'(47 - 6 * i) -: 6];
      row = 2 * int'(six[5]) + int'(six[0]);
      col = int'(six[4:1]);
      s   = {s[27:0], 4'(SB[i][row][col])};
    end
    t = perm({32'h0, s}, 32, 32, P_T);
    return t[31:0];
  endfunction

  // Subkeys come from the cumulative rotation of the original C0/D0 halves.
  function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] p);
    logic [63:0] t;
    logic [27:0] c0, d0, c, d;
    logic [31:0] l, r, tmp;
    logic [47:0] sk;
    int          tot;
    t   = perm(k, 64, 56, PC1_T);
    c0  = t[55:28];
    d0  = t[27:0];
    t   = perm(p, 64, 64, IP_T);
    l   = t[63:32];
    r   = t[31:0];
    tot = 0;
    for (int rnd = 0; rnd < 16; rnd++) begin
      tot += SHIFTS[rnd];
      c   = rotl28(c0, tot);
      d   = rotl28(d0, tot);
      t   = perm({8'h0, c, d}, 56, 48, PC2_T);
      sk  = t[47:0];
      tmp = r;
      r   = l ^ feistel(r, sk);
      l   = tmp;
    end
    return perm({r, l}, 64, 64, FP_T);
  endfunction

  typedef struct {
    logic [63:0] ct;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [63:0] hold_ct = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: results must arrive on their due cycle; the output holds otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ct_dv === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_dv: o_dv=1 at cycle %0d, expected 0", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_int("dv_cycle", cyc, e.due);
          check64("ciphertext", ciphertext, e.ct);
          hold_ct = e.ct;
        end
      end else begin
        check64("ct_hold", ciphertext, hold_ct);
        if (sb_q.size() > 0 && cyc >= sb_q[0].due) begin
          checks++;
          errors++;
          $display("FAIL missing_dv: o_dv=%b at cycle %0d, expected 1", ct_dv, cyc);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [63:0] k, input logic [63:0] p,
                       input logic [63:0] expct, input bit scramble);
    exp_t e;
    @(posedge clk); #1;
    key       = k;
    cleartext = p;
    dv        = 1'b1;
    e.ct      = expct;
    e.due     = cyc + 17;
    sb_q.push_back(e);
    @(posedge clk); #1;
    dv = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (scramble) begin
        key       = {$urandom, $urandom};
        cleartext = {$urandom, $urandom};
        dv        = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    dv = 1'b0;
  endtask

  initial begin
    logic [63:0] k, p, r12;
    int          a;

    repeat (3) @(posedge clk);
    #1;
    check64("reset_ct", ciphertext, 64'h0);
    check64("reset_dv", {63'h0, ct_dv}, 64'h0);
    rst     = 1'b0;
    hold_ct = '0;
    mon_en  = 1'b1;

    issue(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1'b0);
    issue(64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1'b0);
    issue(64'h0101010101010101, 64'h0000000000000000, 64'h8CA64DE9C1B123A7, 1'b0);
    issue(64'h0101010101010101, 64'h95F8A5E5DD31D900, 64'h8000000000000000, 1'b0);
    issue(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1'b1);

    // Continuous i_dv: re-acceptance every 18 cycles.
    r12 = des_ref(64'h3132333435363738, 64'h3132333435363738);
    @(posedge clk); #1;
    key       = 64'h3132333435363738;
    cleartext = 64'h3132333435363738;
    dv        = 1'b1;
    a         = cyc + 1;
    for (int j = 0; j < 4; j++) begin
      exp_t e;
      e.ct  = r12;
      e.due = a + 18 * j + 16;
      sb_q.push_back(e);
    end
    repeat (55) @(posedge clk);
    #1;
    dv = 1'b0;
    repeat (18) @(posedge clk);
    #1;

    // Reset during round 8 aborts the block, and wins over i_dv.
    @(posedge clk); #1;
    key       = {$urandom, $urandom};
    cleartext = {$urandom, $urandom};
    dv        = 1'b1;
    @(posedge clk); #1;
    dv = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    dv  = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
    hold_ct = '0;
    rst     = 1'b0;
    dv      = 1'b0;
    check64("abort_ct", ciphertext, 64'h0);
    check64("abort_dv", {63'h0, ct_dv}, 64'h0);
    repeat (20) @(posedge clk);
    #1;
    issue(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1'b0);

    for (int t = 0; t < 16; t++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(k, p, des_ref(k, p), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
